// File: rtl/led_lights_pkg.sv
// Shared types, constants and the seven-segment encoder for the LED display path.
// Pure declarations; no state, no timing.
package led_lights_pkg;
   localparam logic [3:0]  DIGIT_BLANK = 4'd15;
   localparam int          NUM_DIGITS  = 8;
   localparam logic [15:0] BCD_MAX     = 16'd9999;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_COMMIT
   } sched_state_t;

   // Active-low {g,f,e,d,c,b,a}; any non-decimal code (including blank) is dark.
   function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction
endpackage

// File: rtl/led_display_scheduler_if.sv
// Two producer channels handing 16-bit values to the display scheduler.
// Transfer on valid && ready; producers hold value/valid until ready.
interface led_display_scheduler_if;
   logic [15:0] ch0_value;
   logic        ch0_valid;
   logic        ch0_ready;
   logic [15:0] ch1_value;
   logic        ch1_valid;
   logic        ch1_ready;

   modport master (
      output ch0_value, ch0_valid, ch1_value, ch1_valid,
      input  ch0_ready, ch1_ready
   );

   modport slave (
      input  ch0_value, ch0_valid, ch1_value, ch1_valid,
      output ch0_ready, ch1_ready
   );
endinterface

// File: rtl/bin_to_bcd.sv
// Combinational binary to four BCD digits (input <= 9999), leading zeros blanked.
// Zero latency; no handshake.
module bin_to_bcd
   import led_lights_pkg::*;
(
   input  logic [15:0] bin_in,
   output logic [3:0]  thousands,
   output logic [3:0]  hundreds,
   output logic [3:0]  tens,
   output logic [3:0]  units
);
   logic [15:0] bcd;
   logic        t_zero;
   logic        h_zero;

   always_comb begin
      bcd = '0;
      for (int i = 15; i >= 0; i--) begin
         for (int d = 0; d < 4; d++) begin
            if (bcd[4*d +: 4] >= 4'd5)
               bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
         bcd = {bcd[14:0], bin_in[i]};
      end
   end

   // Units digit is never blanked so that zero still shows as "0".
   assign t_zero    = (bcd[15:12] == 4'd0);
   assign h_zero    = t_zero && (bcd[11:8] == 4'd0);
   assign thousands = t_zero ? DIGIT_BLANK : bcd[15:12];
   assign hundreds  = h_zero ? DIGIT_BLANK : bcd[11:8];
   assign tens      = (h_zero && bcd[7:4] == 4'd0) ? DIGIT_BLANK : bcd[7:4];
   assign units     = bcd[3:0];
endmodule

// File: rtl/led_display_scheduler.sv
// Round-robin shares one bin_to_bcd between two channels and scans an 8-digit display.
// Accept -> buffer written 2 cycles later; ready held low in CONVERT/COMMIT (1 accept per 3 cycles).
module led_display_scheduler
   import led_lights_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   led_display_scheduler_if.slave  ch,
   output logic [7:0]              seg_n,
   output logic [7:0]              an_n,
   output logic                    busy
);
   localparam int             PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);

   sched_state_t                    state_q, state_d;
   logic                            grant;
   logic                            accept;
   logic [15:0]                     req_value;
   logic                            chan_q;
   logic                            last_q;
   logic [15:0]                     operand_q;
   logic                            ovf_q;
   logic [1:0]                      ovf_flag_q;
   logic [NUM_DIGITS-1:0][3:0]      digit_buf_q;
   logic [3:0]                      bcd_thou, bcd_hund, bcd_tens, bcd_unit;
   logic [PW-1:0]                   presc_q;
   logic [2:0]                      idx_q;
   logic                            dp_on;

   always_comb begin
      state_d      = state_q;
      grant        = 1'b0;
      ch.ch0_ready = 1'b0;
      ch.ch1_ready = 1'b0;
      if (ch.ch0_valid && ch.ch1_valid)
         grant = ~last_q;
      else if (ch.ch1_valid)
         grant = 1'b1;
      case (state_q)
         ST_IDLE: begin
            ch.ch0_ready = ch.ch0_valid && !grant;
            ch.ch1_ready = ch.ch1_valid && grant;
            if (ch.ch0_valid || ch.ch1_valid)
               state_d = ST_CONVERT;
         end
         ST_CONVERT: state_d = ST_COMMIT;
         ST_COMMIT:  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign accept    = ch.ch0_ready || ch.ch1_ready;
   assign busy      = (state_q != ST_IDLE);
   assign req_value = grant ? ch.ch1_value : ch.ch0_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   bin_to_bcd u_bin_to_bcd (
      .bin_in    (operand_q),
      .thousands (bcd_thou),
      .hundreds  (bcd_hund),
      .tens      (bcd_tens),
      .units     (bcd_unit)
   );

   // last_q resets to ch1 so ch0 wins the first simultaneous request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan_q      <= 1'b0;
         last_q      <= 1'b1;
         operand_q   <= '0;
         ovf_q       <= 1'b0;
         ovf_flag_q  <= '0;
         digit_buf_q <= {NUM_DIGITS{DIGIT_BLANK}};
      end else begin
         if (accept) begin
            chan_q    <= grant;
            operand_q <= (req_value > BCD_MAX) ? BCD_MAX : req_value;
            ovf_q     <= (req_value > BCD_MAX);
         end
         if (state_q == ST_COMMIT) begin
            digit_buf_q[{chan_q, 2'd0}] <= bcd_thou;
            digit_buf_q[{chan_q, 2'd1}] <= bcd_hund;
            digit_buf_q[{chan_q, 2'd2}] <= bcd_tens;
            digit_buf_q[{chan_q, 2'd3}] <= bcd_unit;
            ovf_flag_q[chan_q]          <= ovf_q;
            last_q                      <= chan_q;
         end
      end
   end

   assign dp_on = ((idx_q == 3'd3) && ovf_flag_q[0]) || ((idx_q == 3'd7) && ovf_flag_q[1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= 3'd0;
         an_n    <= 8'hFE;
         seg_n   <= 8'hFF;
      end else begin
         if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            idx_q   <= idx_q + 3'd1;
         end else begin
            presc_q <= presc_q + 1'b1;
         end
         an_n  <= ~(8'd1 << idx_q);
         seg_n <= {~dp_on, seg7_encode(digit_buf_q[idx_q])};
      end
   end
endmodule

// File: tb/tb_led_display_scheduler.sv
// Directed vector bench for led_display_scheduler with a fast scan divider.
module tb_led_display_scheduler;
   logic       clk;
   logic       rst_n;
   logic [7:0] seg_n;
   logic [7:0] an_n;
   logic       busy;
   int         checks = 0;
   int         errors = 0;

   led_display_scheduler_if bus ();

   led_display_scheduler #(.SCAN_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ch    (bus.slave),
      .seg_n (seg_n),
      .an_n  (an_n),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          c;
      logic [15:0] v;
      logic [7:0]  exp [8];
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input bit c, input logic [15:0] v);
      int n;
      n = 0;
      @(negedge clk);
      if (c) begin bus.ch1_value = v; bus.ch1_valid = 1'b1; end
      else   begin bus.ch0_value = v; bus.ch0_valid = 1'b1; end
      #1;
      while (!(c ? bus.ch1_ready : bus.ch0_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_timeout ch%0d: no ready within %0d cycles", c, n);
      end
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      bus.ch1_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic read_pos(input int p, output logic [7:0] seg);
      logic [7:0] want;
      int n;
      n    = 0;
      want = ~(8'd1 << p);
      @(negedge clk);
      while (an_n !== want && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (n >= 80) begin
         checks++;
         errors++;
         $display("FAIL scan_timeout pos%0d: an_n %h never reached %h", p, an_n, want);
      end
      seg = seg_n;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s;
      logic [7:0] e;
      int acc_ch [4];
      int acc_cyc [4];
      int n_acc, cyc, dual;

      vecs[0] = '{1'b0, 16'd1234,  '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
      vecs[1] = '{1'b1, 16'd42,    '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'hFF, 8'hFF, 8'h99, 8'hA4}};
      vecs[2] = '{1'b1, 16'd12345, '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h90, 8'h90, 8'h90, 8'h10}};
      vecs[3] = '{1'b1, 16'd5,     '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'h92}};
      vecs[4] = '{1'b0, 16'd0,     '{8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'h92}};
      vecs[5] = '{1'b0, 16'd10000, '{8'h90, 8'h90, 8'h90, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'h92}};
      vecs[6] = '{1'b0, 16'd9999,  '{8'h90, 8'h90, 8'h90, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'h92}};
      vecs[7] = '{1'b0, 16'd506,   '{8'hFF, 8'h92, 8'hC0, 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'h92}};
      vecs[8] = '{1'b1, 16'd7,     '{8'hFF, 8'h92, 8'hC0, 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'hF8}};

      rst_n         = 1'b0;
      bus.ch0_value = '0;
      bus.ch0_valid = 1'b0;
      bus.ch1_value = '0;
      bus.ch1_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state, then scan stepping: after edge k the index is (k-1)/4 mod 8.
      chk("rst_an_n", an_n, 8'hFE);
      chk("rst_seg_n", seg_n, 8'hFF);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ready", {6'd0, bus.ch1_ready, bus.ch0_ready}, 8'd0);
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         e = ~(8'd1 << (((k - 1) / 4) % 8));
         chk($sformatf("scan_k%0d", k), an_n, e);
      end

      // Accept / busy timing for a single ch0 transfer.
      @(negedge clk);
      bus.ch0_value = 16'd1234;
      bus.ch0_valid = 1'b1;
      #1;
      chk("t_ready0_accept", {7'd0, bus.ch0_ready}, 8'd1);
      chk("t_ready1_accept", {7'd0, bus.ch1_ready}, 8'd0);
      chk("t_busy_accept", {7'd0, busy}, 8'd0);
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      @(negedge clk);
      chk("t_busy_convert", {7'd0, busy}, 8'd1);
      chk("t_ready_convert", {7'd0, bus.ch0_ready}, 8'd0);
      @(negedge clk);
      chk("t_busy_commit", {7'd0, busy}, 8'd1);
      @(negedge clk);
      chk("t_busy_idle", {7'd0, busy}, 8'd0);
      read_pos(0, s);
      chk("t_pos0_1234", s, 8'hF9);

      for (int i = 0; i < 9; i++) begin
         send(vecs[i].c, vecs[i].v);
         for (int p = 0; p < 8; p++) begin
            read_pos(p, s);
            chk($sformatf("vec%0d_pos%0d", i, p), s, vecs[i].exp[p]);
         end
      end

      // Both channels held valid: strict alternation starting with ch0, 3-cycle spacing.
      for (int j = 0; j < 4; j++) begin acc_ch[j] = 9; acc_cyc[j] = -100; end
      n_acc = 0; cyc = 0; dual = 0;
      @(negedge clk);
      bus.ch0_value = 16'd1111;
      bus.ch1_value = 16'd2222;
      bus.ch0_valid = 1'b1;
      bus.ch1_valid = 1'b1;
      #1;
      while (n_acc < 4 && cyc < 40) begin
         if (bus.ch0_ready && bus.ch1_ready) dual++;
         if (bus.ch0_ready) begin acc_ch[n_acc] = 0; acc_cyc[n_acc] = cyc; n_acc++; end
         else if (bus.ch1_ready) begin acc_ch[n_acc] = 1; acc_cyc[n_acc] = cyc; n_acc++; end
         @(posedge clk);
         #1;
         if (n_acc == 4) begin bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0; end
         @(negedge clk);
         cyc++;
      end
      chk("alt_count", 8'(n_acc), 8'd4);
      chk("alt_dual_ready", 8'(dual), 8'd0);
      for (int j = 0; j < 4; j++)
         chk($sformatf("alt_grant%0d", j), 8'(acc_ch[j]), 8'(j % 2));
      for (int j = 1; j < 4; j++)
         chk($sformatf("alt_gap%0d", j), 8'(acc_cyc[j] - acc_cyc[j-1]), 8'd3);
      repeat (4) @(negedge clk);

      // Reset during CONVERT of ch0=5678.
      bus.ch0_value = 16'd5678;
      bus.ch0_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.ch0_valid = 1'b0;
      @(negedge clk);
      chk("mr_busy_convert", {7'd0, busy}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_busy", {7'd0, busy}, 8'd0);
      chk("mr_an_n", an_n, 8'hFE);
      chk("mr_seg_n", seg_n, 8'hFF);
      chk("mr_ready", {6'd0, bus.ch1_ready, bus.ch0_ready}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int p = 0; p < 8; p++) begin
         read_pos(p, s);
         chk($sformatf("mr_blank_pos%0d", p), s, 8'hFF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_display_scheduler.md
# led_display_scheduler

Time-shares one `bin_to_bcd` converter between two 16-bit display channels and drives an 8-digit multiplexed seven-segment display. Producers hand over values through valid/ready handshakes. The scheduler arbitrates round-robin, converts each accepted value to four BCD digits and commits them atomically into a digit buffer. A free-running scan refreshes the display from that buffer. It sits between the value producers and the board LED/segment pins in the led_lights module.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit; legal range ≥ 2.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ch0_value`  in  16  channel 0 binary value; held stable while `ch0_valid` is high.
- `ch0_valid`  in  1  channel 0 request.
- `ch0_ready`  out  1  channel 0 accept; transfer occurs when valid && ready.
- `ch1_value`  in  16  channel 1 binary value.
- `ch1_valid`  in  1  channel 1 request.
- `ch1_ready`  out  1  channel 1 accept.
- `seg_n`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- `an_n`  out  8  digit enables, one-hot active-low, registered.
- `busy`  out  1  high in CONVERT or COMMIT.

## Operation
- Digit buffer: 8 × 4 bits. Positions 0–3 hold ch0 (thousands..units), positions 4–7 hold ch1. Value 15 is blank.
- FSM states are IDLE, CONVERT and COMMIT.
  - IDLE: if any valid, grant one channel. `chX_ready` = (state==IDLE) && grant==X, combinational. On accept, latch the operand and channel id, then go to CONVERT.
  - CONVERT: the operand drives `bin_to_bcd.bin_in`, then go to COMMIT.
  - COMMIT: write all 4 converter digits into the granted channel's buffer slots in one cycle, update the round-robin pointer, then go to IDLE.
- Arbitration: if only one channel is valid, grant it. If both are valid, grant the channel not served last. After reset, ch0 has priority.
- Saturation: operand > 9999 is clamped to 9999 before conversion, and that channel's overflow flag is set. Any in-range commit clears the flag. The flag lights dp on the channel's units digit (position 3 or 7).
- Leading-zero suppression comes from the converter (digit 15). Value 0 displays as three blanks followed by "0".
- Scan: a prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→7→0.
  - `an_n` = ~(1 << index).
  - `seg_n` = 7-segment decode of buffer[index], with dp per the rule above.
  - Digit 15 decodes to 8'hFF, all segments off.

## Timing
- Reset values:
  - state IDLE, `busy` 0, both `ready` 0 until a valid appears.
  - All buffer digits 15, overflow flags 0, pointer favours ch0.
  - Prescaler 0, index 0, `an_n` 8'hFE, `seg_n` 8'hFF.
- Accept at edge T. CONVERT during T..T+1. COMMIT writes the buffer at edge T+2. `seg_n` reflects the new digit at edge T+3 if that position is being scanned.
- Throughput: one accept per 3 cycles. `ready` is low for the cycles in CONVERT and COMMIT.
- A valid asserted while busy is held, not dropped. The producer keeps valid and value stable until its ready is seen.
- Simultaneous valids alternate strictly: ch0, ch1, ch0, … while both stay high.
- Buffer writes never tear. A scan read in the COMMIT cycle sees the old digit; the next read sees all 4 new digits.
- Reset asserted mid-conversion discards the operand, blanks the display and returns to IDLE asynchronously.
- Prescaler wrap and digit-index wrap (7→0) occur in the same cycle; there is no skipped or repeated digit.

## Structure
- Shared package `led_lights_pkg` contains:
  - `DIGIT_BLANK` = 4'd15, `NUM_DIGITS` = 8, `BCD_MAX` = 16'd9999.
  - FSM state enum `sched_state_t`.
  - Function `seg7_encode(4-bit digit) → 7-bit active-low pattern`.
- Sub-module: one instance of the existing `bin_to_bcd` (16-bit in, 4 × 4-bit out). No other sub-module.

## Test plan
- Reset only → `an_n`=8'hFE, `seg_n`=8'hFF, `busy`=0; with SCAN_DIV=4, `an_n` steps FE, FD, FB, … 7F, FE every 4 cycles.
- ch0 sends 1234 → `ch0_ready` high in the accept cycle, `busy` for 2 cycles; buffer[0..3] = 1,2,3,4; `seg_n` at position 0 = 8'hF9 ("1").
- ch1 sends 42 → buffer[4..7] = 15,15,4,2; positions 4 and 5 drive 8'hFF; ch0 digits unchanged.
- ch0 and ch1 both valid, held for 4 transfers → grants ch0, ch1, ch0, ch1; accepts spaced exactly 3 cycles apart.
- ch1 sends 12345 → buffer[4..7] = 9,9,9,9 and position 7 has dp low (`seg_n[7]`=0). A following ch1 value of 5 clears dp and shows blank, blank, blank, 5.
- `rst_n` pulsed low during CONVERT of ch0=5678 → outputs return to reset values immediately; the buffer stays blank after release.
